// File: rtl/imem_boot_loader.sv
// imem_boot_loader: framed byte-stream loader for the 32-byte instruction memory with checksum gate on cpu_run.
// Optional idle timeout in LEN/DATA/CSUM is enabled by defining BOOT_TIMEOUT_EN.
module imem_boot_loader #(
    parameter int MEM_BYTES      = 32,
    parameter int ADDR_W         = 5,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [7:0]        im_wdata,
    output logic              cpu_run,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   byte_count
);
    typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE, ERROR} state_t;

    if ((2 ** ADDR_W) < MEM_BYTES || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("imem_boot_loader: illegal parameter combination");
    end

    state_t          state_q, state_d;
    logic [ADDR_W:0] len_q, len_d, cnt_q, cnt_d;
    logic [7:0]      csum_q, csum_d;
    logic            acc, timeout;

    assign acc        = in_valid && in_ready;
    assign byte_count = cnt_q;

`ifdef BOOT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_q;

    // Counter stays clear outside a session, so entering LEN always starts from zero.
    assign timeout = busy && !acc && (idle_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || !busy || acc)
            idle_q <= '0;
        else
            idle_q <= idle_q + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        case (state_q)
            IDLE, DONE, ERROR: if (start) begin
                state_d = LEN;
                len_d   = '0;
                cnt_d   = '0;
                csum_d  = '0;
            end
            LEN: if (acc) begin
                if (in_data == 8'd0 || in_data > 8'(MEM_BYTES))
                    state_d = ERROR;
                else begin
                    len_d   = (ADDR_W+1)'(in_data);
                    state_d = DATA;
                end
            end
            DATA: if (acc) begin
                cnt_d   = cnt_q + 1'b1;
                csum_d  = csum_q + in_data;
                state_d = (cnt_d == len_q) ? CSUM : DATA;
            end
            CSUM: if (acc) state_d = (in_data == csum_q) ? DONE : ERROR;
            default: ;
        endcase
        if (timeout) state_d = ERROR;
    end

    // Status outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            csum_q   <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_run  <= 1'b0;
            im_we    <= 1'b0;
            im_addr  <= '0;
            im_wdata <= '0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            csum_q   <= csum_d;
            in_ready <= state_d inside {LEN, DATA, CSUM};
            busy     <= state_d inside {LEN, DATA, CSUM};
            done     <= state_d == DONE;
            error    <= state_d == ERROR;
            cpu_run  <= state_d == DONE;
            im_we    <= acc && state_q == DATA;
            if (acc && state_q == DATA) begin
                im_addr  <= cnt_q[ADDR_W-1:0];
                im_wdata <= in_data;
            end
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: table vectors, hand sequences and random frames checked against a frame-level model.
module tb_imem_boot_loader;
    localparam int MB = 32;
    localparam int AW = 5;

    logic          clk = 0, rst = 1, start = 0, in_valid = 0;
    logic [7:0]    in_data = 0;
    logic          in_ready, im_we, cpu_run, busy, done, error;
    logic [AW-1:0] im_addr;
    logic [7:0]    im_wdata;
    logic [AW:0]   byte_count;

    imem_boot_loader #(.MEM_BYTES(MB), .ADDR_W(AW), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_run(cpu_run), .busy(busy), .done(done), .error(error), .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    int         errors = 0, checks = 0, busy_cyc = 0;
    int         wa[$], wd[$];
    bit         rnd = 0;
    logic [7:0] frame[$];

    typedef struct {
        logic [7:0]  len;
        logic [31:0] pay;
        logic [7:0]  csum;
        bit          edone;
        int          ebc;
    } vec_t;
    vec_t vecs[7];

    always @(negedge clk) begin
        if (im_we) begin
            wa.push_back(int'(im_addr));
            wd.push_back(int'(im_wdata));
        end
        if (busy) busy_cyc++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic push(input logic [7:0] b);
        int t = 0;
        in_valid = 1;
        in_data  = b;
        if (rnd) start = ($urandom_range(0, 7) == 0);
        while (!in_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("push_ready", int'(in_ready), 1);
            in_valid = 0;
            start    = 0;
            return;
        end
        @(negedge clk);
        in_valid = 0;
        start    = 0;
        if (rnd) repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic run_frame(input bit edone, input int ebc);
        wa.delete();
        wd.delete();
        busy_cyc = 0;
        start_pulse();
        foreach (frame[i]) push(frame[i]);
        repeat (2) @(negedge clk);
        chk("done", int'(done), int'(edone));
        chk("error", int'(error), int'(!edone));
        chk("cpu_run", int'(cpu_run), int'(edone));
        chk("busy_end", int'(busy), 0);
        chk("in_ready_end", int'(in_ready), 0);
        chk("byte_count", int'(byte_count), ebc);
        chk("n_writes", wa.size(), ebc);
        for (int i = 0; i < wa.size() && i < ebc; i++) begin
            chk("wr_addr", wa[i], i);
            chk("wr_data", wd[i], int'(frame[i+1]));
        end
    endtask

    // Frame-level reference: legal length, payload sum mod 256 against the trailing byte.
    function automatic void model(output bit edone, output int ebc);
        int n = int'(frame[0]);
        int s = 0;
        bit ok = n >= 1 && n <= MB;
        if (ok) for (int i = 1; i <= n; i++) s += int'(frame[i]);
        edone = ok && ((s % 256) == int'(frame[n+1]));
        ebc   = ok ? n : 0;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_im_we"}, int'(im_we), 0);
        chk({tag, "_cpu_run"}, int'(cpu_run), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_error"}, int'(error), 0);
        chk({tag, "_im_addr"}, int'(im_addr), 0);
        chk({tag, "_im_wdata"}, int'(im_wdata), 0);
        chk({tag, "_byte_count"}, int'(byte_count), 0);
    endtask

    initial begin
        vecs[0] = '{8'h04, 32'h20080005, 8'h2D, 1'b1, 4};
        vecs[1] = '{8'h04, 32'h20080005, 8'h2C, 1'b0, 4};
        vecs[2] = '{8'h00, 32'h0,        8'h00, 1'b0, 0};
        vecs[3] = '{8'h21, 32'h0,        8'h00, 1'b0, 0};
        vecs[4] = '{8'h01, 32'hFF000000, 8'hFF, 1'b1, 1};
        vecs[5] = '{8'h02, 32'h80800000, 8'h00, 1'b1, 2};
        vecs[6] = '{8'h03, 32'hA1B2C300, 8'h16, 1'b1, 3};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 0;

        foreach (vecs[v]) begin
            frame = {vecs[v].len};
            if (vecs[v].len >= 1 && vecs[v].len <= 4) begin
                for (int i = 0; i < int'(vecs[v].len); i++) frame.push_back(vecs[v].pay[31-8*i -: 8]);
                frame.push_back(vecs[v].csum);
            end
            run_frame(vecs[v].edone, vecs[v].ebc);
        end

        // Full 32-byte frame, back to back: one byte per cycle, last write at 1F.
        frame = {8'd32};
        for (int i = 0; i < 32; i++) frame.push_back(8'(i));
        frame.push_back(8'hF0);
        run_frame(1'b1, 32);
        chk("full_last_addr", wa.size() > 0 ? wa[wa.size()-1] : -1, 31);
        chk("full_busy_cycles", busy_cyc, 34);
        start_pulse();
        chk("restart_cpu_run", int'(cpu_run), 0);
        chk("restart_busy", int'(busy), 1);
        chk("restart_done", int'(done), 0);
        push(8'h00);
        @(negedge clk);
        chk("restart_len0_error", int'(error), 1);

        // Reset in the middle of a payload, coinciding with another accepted byte.
        wa.delete();
        wd.delete();
        start_pulse();
        push(8'h04);
        push(8'h11);
        push(8'h22);
        in_valid = 1;
        in_data  = 8'h33;
        rst      = 1;
        @(negedge clk);
        in_valid = 0;
        rst      = 0;
        check_reset_outputs("midrst");
        repeat (3) @(negedge clk);
        chk("midrst_writes", wa.size(), 2);
        chk("midrst_busy_after", int'(busy), 0);
        frame = {8'd32};
        for (int i = 0; i < 32; i++) frame.push_back(8'(i));
        frame.push_back(8'hF0);
        run_frame(1'b1, 32);

        // Length accepted, then the stream stalls.
        start_pulse();
        push(8'h04);
        repeat (20) @(negedge clk);
`ifdef BOOT_TIMEOUT_EN
        chk("stall_error", int'(error), 1);
        chk("stall_in_ready", int'(in_ready), 0);
        chk("stall_busy", int'(busy), 0);
`else
        chk("stall_error", int'(error), 0);
        chk("stall_in_ready", int'(in_ready), 1);
        chk("stall_busy", int'(busy), 1);
`endif
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("stall_rst_busy", int'(busy), 0);

        rnd = 1;
        for (int f = 0; f < 40; f++) begin
            int  n, s, ebc;
            bit  edone;
            n = ($urandom_range(0, 9) == 0) ? (($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(33, 255)))
                                            : int'($urandom_range(1, MB));
            frame = {8'(n)};
            if (n >= 1 && n <= MB) begin
                s = 0;
                for (int i = 0; i < n; i++) begin
                    frame.push_back(8'($urandom));
                    s += int'(frame[i+1]);
                end
                frame.push_back(($urandom_range(0, 1) == 0) ? 8'(s) : 8'($urandom));
            end
            model(edone, ebc);
            run_frame(edone, ebc);
        end
        rnd = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream feeder for the single-cycle processor's byte-wide instruction memory (32 bytes, big-endian, MSB byte at the lowest address).
- Accepts a framed byte stream over a valid/ready handshake and writes the payload bytes into instruction memory.
- Checks an 8-bit additive checksum, then raises cpu_run to release the processor to fetch from PC 0.

Parameters:
- MEM_BYTES, 32, instruction memory size in bytes; legal frame lengths are 1..MEM_BYTES.
- ADDR_W, 5, instruction memory byte-address width; must satisfy 2**ADDR_W >= MEM_BYTES.
- TIMEOUT_CYCLES, 1024, idle-cycle limit between accepted bytes; used only with BOOT_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load session.
- in_valid  in  1  stream byte valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader can accept a byte.
- im_we  out  1  instruction memory byte-write strobe.
- im_addr  out  ADDR_W  instruction memory byte address.
- im_wdata  out  8  instruction memory write data.
- cpu_run  out  1  processor enable; high only after a verified load.
- busy  out  1  session in progress (states LEN, DATA, CSUM).
- done  out  1  load verified.
- error  out  1  load failed.
- byte_count  out  ADDR_W+1  payload bytes accepted in the current session.

Behaviour:
- Clock is clk. Reset is rst, synchronous and active-high: it acts only on a rising clk edge while rst=1.
- Reset values: state IDLE; in_ready, im_we, cpu_run, busy, done, error = 0; im_addr, im_wdata, byte_count = 0; internal length and checksum registers = 0.
- Handshake: a byte is accepted on a rising edge where in_valid && in_ready. in_ready is a registered output, high exactly in states LEN, DATA and CSUM. in_data is don't-care when in_valid is 0.
- FSM states: IDLE, LEN, DATA, CSUM, DONE, ERROR.
- IDLE: start=1 -> LEN. Length, checksum and byte_count clear on the same edge.
- LEN: on an accepted byte N:
  - N == 0 or N > MEM_BYTES -> ERROR; no memory writes occur.
  - Otherwise store N and go to DATA.
- DATA: the k-th accepted byte (k from 0):
  - drives im_we=1, im_addr=k, im_wdata=byte for exactly the next cycle (one-cycle write latency);
  - adds the byte to the checksum modulo 256 (8-bit wrap);
  - increments byte_count.
  - When byte_count reaches N -> CSUM.
- CSUM: accepted byte == checksum -> DONE, otherwise -> ERROR.
- DONE: done=1, cpu_run=1. Both hold until rst or start.
- ERROR: error=1, cpu_run=0. Holds until rst or start.
- start in DONE or ERROR -> LEN on the same edge: done, error and cpu_run drop; counters clear.
- start while busy is ignored; the session continues.
- At most one im_we pulse per accepted byte. im_we is never asserted outside DATA plus the one trailing cycle.
- rst mid-session -> IDLE on that edge. A pending im_we is suppressed. Memory bytes already written are not erased.
- Addresses never wrap: the N <= MEM_BYTES check guarantees im_addr <= MEM_BYTES-1.
- Back-to-back accepted bytes (in_valid held high) sustain one byte per cycle.

Optional Feature:
- Macro: BOOT_TIMEOUT_EN.
- Defined: an idle counter clears on every accepted byte and on entry to LEN. It increments each busy cycle with no acceptance. Reaching TIMEOUT_CYCLES -> ERROR; in_ready drops on that edge.
- Not defined: no counter; the loader waits indefinitely in LEN, DATA and CSUM.

Test Plan:
- Reset then start; stream 04, 20 08 00 05, checksum 2D -> im_we pulses at addresses 0..3 with data 20,08,00,05; done=1, cpu_run=1, byte_count=4.
- Same frame with checksum 2C -> 4 writes still occur; error=1, cpu_run=0, done=0.
- Length byte 00, then separately length byte 21 (33) -> ERROR immediately in both cases; zero im_we pulses.
- Full frame: length 20 (32), bytes 00..1F, checksum F0 -> last write is im_addr=1F; done=1. Then start -> cpu_run=0 and busy=1 on the next cycle.
- rst asserted after 2 of 4 payload bytes -> next cycle all outputs are at reset values, no further im_we; a fresh start and a full frame then completes with done=1.
- With BOOT_TIMEOUT_EN and TIMEOUT_CYCLES=16: send length 04 then idle 16 cycles -> error=1 and in_ready=0. Without the macro, the same stimulus leaves busy=1 indefinitely.
